hd44780_text_buffer: RTL and testbench

Character frame buffer and refresh sequencer that sits directly upstream of the HD44780 4-bit driver. It holds 64 display characters written by a host port, and serves the driver's character fetch bus: the driver's `idataaddr` drives `rd_addr`, and `rd_data` drives the driver's `idata`. It pulses the driver's `trg` whenever the contents have changed and the driver is idle, subject to a holdoff.

---
 rtl/hd44780_text_buffer.sv | 178 +++++++++++++++++
 tb/tb_hd44780_text_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hd44780_text_buffer.sv
// Character frame buffer and refresh sequencer feeding an HD44780 4-bit driver.
// Optional HD44780_BUF_RESET_FILL_EN: run the fill engine automatically after reset.
module hd44780_text_buffer #(
    parameter int              MEM_DEPTH       = 64,
    parameter int              ADDR_BITS       = 6,
    parameter int              DATA_WIDTH      = 8,
    parameter logic [7:0]      FILL_CHAR       = 8'h20,
    parameter int              REFRESH_HOLDOFF = 250,
    parameter int              BUSY_TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clear,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  lcd_busy,
    output logic                  lcd_trg,
    output logic                  dirty,
    output logic                  clearing
);

    localparam int CNT_MAX = (REFRESH_HOLDOFF > BUSY_TIMEOUT) ? REFRESH_HOLDOFF : BUSY_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(MEM_DEPTH - 1);

`ifdef HD44780_BUF_RESET_FILL_EN
    localparam logic CLEARING_RST = 1'b1;
`else
    localparam logic CLEARING_RST = 1'b0;
`endif

    typedef enum logic [2:0] {
        R_IDLE,
        R_HOLD,
        R_TRIG,
        R_WAIT,
        R_BUSY
    } r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    r_state_t              state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]  fill_ptr_q, fill_ptr_d;
    logic                  clearing_q, clearing_d;
    logic                  dirty_q, dirty_d;
    logic                  lcd_trg_q, lcd_trg_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                  wr_accept;
    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign wr_ready  = !clearing_q;
    assign wr_accept = wr_valid && wr_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_ptr_d = fill_ptr_q;
        clearing_d = clearing_q;
        dirty_d    = dirty_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = wr_data;

        // The fill engine owns the write port; host writes are refused while it runs.
        if (clearing_q) begin
            mem_we    = 1'b1;
            mem_waddr = fill_ptr_q;
            mem_wdata = DATA_WIDTH'(FILL_CHAR);
            if (fill_ptr_q == LAST_ADDR) begin
                fill_ptr_d = '0;
                clearing_d = 1'b0;
                dirty_d    = 1'b1;
            end else begin
                fill_ptr_d = fill_ptr_q + ADDR_BITS'(1);
            end
        end else begin
            mem_we = wr_accept;
            if (clear) begin
                clearing_d = 1'b1;
                fill_ptr_d = '0;
            end
        end

        case (state_q)
            R_IDLE: begin
                if (dirty_q && !lcd_busy && !clearing_q) begin
                    cnt_d   = CNT_W'(REFRESH_HOLDOFF);
                    state_d = R_HOLD;
                end
            end
            R_HOLD: begin
                if (lcd_busy || clearing_q) begin
                    state_d = R_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = R_TRIG;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            R_TRIG: begin
                dirty_d = 1'b0;
                cnt_d   = CNT_W'(BUSY_TIMEOUT);
                state_d = R_WAIT;
            end
            R_WAIT: begin
                if (lcd_busy) begin
                    state_d = R_BUSY;
                end else if (cnt_q == '0) begin
                    // Driver never acknowledged the trigger: mark dirty so it is retried.
                    dirty_d = 1'b1;
                    state_d = R_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            R_BUSY: begin
                if (!lcd_busy) begin
                    state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase

        // A host write always wins over the trigger's dirty clear.
        if (wr_accept) begin
            dirty_d = 1'b1;
        end

        lcd_trg_d = (state_d == R_TRIG);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= R_IDLE;
            cnt_q      <= '0;
            fill_ptr_q <= '0;
            clearing_q <= CLEARING_RST;
            dirty_q    <= 1'b0;
            lcd_trg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_ptr_q <= fill_ptr_d;
            clearing_q <= clearing_d;
            dirty_q    <= dirty_d;
            lcd_trg_q  <= lcd_trg_d;
        end
    end

    // Storage has no reset so it maps onto block RAM; read-before-write on collision.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data  = rd_data_q;
    assign lcd_trg  = lcd_trg_q;
    assign dirty    = dirty_q;
    assign clearing = clearing_q;

endmodule

// File: tb/tb_hd44780_text_buffer.sv
// Directed bench for hd44780_text_buffer: a timestamp-based behavioural model is
// compared against the DUT every cycle, plus hand-computed latency/data literals.
module tb_hd44780_text_buffer;

    localparam int         D    = 64;
    localparam int         H    = 4;
    localparam int         BT   = 15;
    localparam logic [7:0] FILL = 8'h20;
`ifdef HD44780_BUF_RESET_FILL_EN
    localparam bit RESET_FILL = 1'b1;
`else
    localparam bit RESET_FILL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [5:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       clear = 1'b0;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       lcd_busy = 1'b0;
    logic       lcd_trg;
    logic       dirty;
    logic       clearing;

    logic       sweep = 1'b0;
    logic [5:0] sweep_addr = '0;
    logic [5:0] rd_fix = '0;
    assign rd_addr = sweep ? sweep_addr : rd_fix;

    int  n_cmp = 0;
    int  n_fail = 0;
    int  trg_seen = 0;
    bit  cmp_en = 1'b0;

    hd44780_text_buffer #(
        .MEM_DEPTH(D), .ADDR_BITS(6), .DATA_WIDTH(8), .FILL_CHAR(FILL),
        .REFRESH_HOLDOFF(H), .BUSY_TIMEOUT(BT)
    ) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .clear(clear),
        .rd_addr(rd_addr), .rd_data(rd_data), .lcd_busy(lcd_busy),
        .lcd_trg(lcd_trg), .dirty(dirty), .clearing(clearing)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phases with absolute cycle deadlines, memory as a plain array.
    localparam int P_IDLE = 0, P_HOLD = 1, P_TRIG = 2, P_WAIT = 3, P_BUSY = 4;
    logic [7:0] m_mem   [D];
    bit         m_known [D];
    int  m_phase, m_fill_left, cyc, trig_cycle, wait_last;
    bit  m_dirty, m_rd_known, acc, filling;
    logic [7:0] m_rd;

    initial for (int i = 0; i < D; i++) m_known[i] = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fill_left = RESET_FILL ? D : 0;
            m_dirty     = 1'b0;
            m_phase     = P_IDLE;
            m_rd        = 8'h00;
            m_rd_known  = 1'b1;
            cyc         = 0;
        end else begin
            cyc++;
            filling    = (m_fill_left != 0);
            acc        = wr_valid && !filling;
            m_rd       = m_mem[rd_addr];
            m_rd_known = m_known[rd_addr];
            case (m_phase)
                P_IDLE: if (m_dirty && !lcd_busy && !filling) begin
                    m_phase = P_HOLD; trig_cycle = cyc + H + 1;
                end
                P_HOLD: if (lcd_busy || filling) m_phase = P_IDLE;
                        else if (cyc == trig_cycle) m_phase = P_TRIG;
                P_TRIG: begin m_dirty = 1'b0; m_phase = P_WAIT; wait_last = cyc + BT; end
                P_WAIT: if (lcd_busy) m_phase = P_BUSY;
                        else if (cyc - 1 == wait_last) begin m_dirty = 1'b1; m_phase = P_IDLE; end
                default: if (!lcd_busy) m_phase = P_IDLE;
            endcase
            if (acc) begin
                m_dirty = 1'b1;
                m_mem[wr_addr] = wr_data;
                m_known[wr_addr] = 1'b1;
            end
            if (filling) begin
                m_mem[D - m_fill_left] = FILL;
                m_known[D - m_fill_left] = 1'b1;
                m_fill_left--;
                if (m_fill_left == 0) m_dirty = 1'b1;
            end else if (clear) begin
                m_fill_left = D;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            check("wr_ready", wr_ready, m_fill_left == 0);
            check("clearing", clearing, m_fill_left != 0);
            check("dirty", dirty, m_dirty);
            check("lcd_trg", lcd_trg, m_phase == P_TRIG);
            if (m_rd_known) check("rd_data", rd_data, m_rd);
        end
        if (!rst && lcd_trg) trg_seen++;
        if (sweep) sweep_addr <= sweep_addr + 6'd1;
    end

    task automatic wait_trg(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!lcd_trg && n < 200);
    endtask

    task automatic measure_fill(output int n);
        n = 0;
        while (clearing && n < 200) begin n++; @(negedge clk); end
    endtask

    task automatic host_write(input logic [5:0] a, input logic [7:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Called at the negedge where lcd_trg is seen; emulates a driver print.
    task automatic busy_window();
        lcd_busy = 1'b1;
        repeat (5) @(negedge clk);
        lcd_busy = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    int n, t0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_lcd_trg", lcd_trg, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_dirty", dirty, 0);
        check("rst_clearing", clearing, RESET_FILL);
        check("rst_wr_ready", wr_ready, !RESET_FILL);
        $display("TXN reset released");
        rst = 1'b0;
        cmp_en = 1'b1;
        if (!RESET_FILL) begin
            clear = 1'b1; @(negedge clk); clear = 0;
        end

        measure_fill(n);
        check("fill_len", n, 64);
        wait_trg(n);
        check("fill_trg_gap", n, 6);
        $display("TXN initial fill len ok, trigger after %0d", n);
        busy_window();
        check("dirty_after_print", dirty, 0);
        sweep = 1'b1;
        repeat (66) @(negedge clk);
        sweep = 1'b0;
        $display("TXN swept all addresses");

        host_write(6'd5, 8'h41);
        rd_fix = 6'd5;
        @(negedge clk);
        check("rd_after_write", rd_data, 8'h41);
        wr_valid = 1'b1; wr_addr = 6'd7; wr_data = 8'h42; rd_fix = 6'd7;
        @(negedge clk);
        wr_valid = 1'b0;
        check("rd_collision_old", rd_data, 8'h20);
        @(negedge clk);
        check("rd_collision_new", rd_data, 8'h42);
        $display("TXN write/read and collision");
        wait_trg(n);
        check("trg_after_write", n < 200, 1);
        busy_window();

        host_write(6'd8, 8'h43);
        wait_trg(n);
        lcd_busy = 1'b1;
        repeat (2) @(negedge clk);
        host_write(6'd8, 8'h44);
        check("dirty_in_busy", dirty, 1);
        repeat (3) @(negedge clk);
        lcd_busy = 1'b0;
        wait_trg(n);
        check("busy_write_retrig", n, 7);
        busy_window();
        check("dirty_after_retrig", dirty, 0);
        $display("TXN write during busy -> retrigger after %0d", n);

        host_write(6'd9, 8'h45);
        wait_trg(n);
        wr_valid = 1'b1; wr_addr = 6'd9; wr_data = 8'h46; lcd_busy = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        check("dirty_trig_write", dirty, 1);
        repeat (4) @(negedge clk);
        lcd_busy = 1'b0;
        wait_trg(n);
        check("trig_write_second", n, 7);
        busy_window();
        check("dirty_after_second", dirty, 0);
        $display("TXN write in trigger cycle");

        host_write(6'd10, 8'h47);
        wait_trg(n);
        n = 0;
        do begin @(negedge clk); n++; end while (!dirty && n < 100);
        check("timeout_dirty", n, 17);
        wait_trg(n);
        check("retry_trg", n, 6);
        busy_window();
        $display("TXN busy timeout retry");

        host_write(6'd11, 8'h48);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        t0 = trg_seen;
        measure_fill(n);
        check("hold_clear_fill", n, 64);
        check("no_trg_in_fill", trg_seen - t0, 0);
        wait_trg(n);
        check("hold_clear_trg", n, 6);
        busy_window();
        $display("TXN clear during holdoff");

        wr_valid = 1'b1; wr_addr = 6'd3; wr_data = 8'h55; clear = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0; clear = 1'b0;
        repeat (10) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        measure_fill(n);
        check("clear_write_fill", n, 53);
        rd_fix = 6'd3;
        repeat (2) @(negedge clk);
        check("clear_overwrites", rd_data, 8'h20);
        wait_trg(n);
        busy_window();
        $display("TXN clear with same-cycle write, clear ignored mid-fill");

        clear = 1'b1; @(negedge clk); clear = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        #1 check("midfill_rst_clearing", clearing, RESET_FILL);
        check("midfill_rst_dirty", dirty, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        if (!RESET_FILL) begin
            check("no_autofill", clearing, 0);
            clear = 1'b1; @(negedge clk); clear = 1'b0;
        end
        measure_fill(n);
        check("refill_len", n, 64);
        wait_trg(n);
        check("refill_trg", n, 6);
        #1 rst = 1'b1;
        #1 check("async_trg_drop", lcd_trg, 0);
        $display("TXN reset mid-fill and mid-trigger");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
